matrix_mul_seq: RTL

Sequential, parametrised successor to the combinational matrix multiplier in the Calculation datapath. It computes C = A x B for matrices up to MAX_DIM x MAX_DIM using a single multiply-accumulate (MAC) per cycle, under a start/busy/done handshake. Results are either wrapped or saturated to ELEM_WIDTH, and an overflow flag reports any element that exceeded the element range. It sits between the operand-entry logic and the display/result path, and replaces the single-cycle combinational unit so the design meets timing at larger dimensions.

---
 rtl/matrix_mul_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/matrix_mul_seq.sv
// Sequential matrix multiplier: C = A x B with one MAC per cycle under a
// start/busy/done handshake, with wrap or saturate of each result element.
module matrix_mul_seq #(
  parameter int MAX_DIM    = 5,
  parameter int ELEM_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*ELEM_WIDTH+3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  sat_en,
  input  logic [2:0]                            a_m,
  input  logic [2:0]                            a_n,
  input  logic [2:0]                            b_m,
  input  logic [2:0]                            b_n,
  input  logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] matrixA_in,
  input  logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] matrixB_in,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic                                  ovf,
  output logic                                  valid,
  output logic [2:0]                            c_m,
  output logic [2:0]                            c_n,
  output logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] matrix_out
);

  localparam int NE = MAX_DIM*MAX_DIM;
  localparam int IW = $clog2(NE+1);

  typedef logic [NE-1:0][ELEM_WIDTH-1:0] mat_t;
  typedef enum logic [2:0] {IDLE, CHECK, MAC, WRITE, DONE} state_t;

  state_t               state, state_nx;
  mat_t                 a_q, b_q, c_q;
  logic [2:0]           am_q, an_q, bm_q, bn_q;
  logic                 sat_q;
  logic [2:0]           i_q, j_q, k_q;
  logic [ACC_WIDTH-1:0] acc_q, prod;
  logic [IW-1:0]        a_idx, b_idx, c_idx;
  logic                 dim_bad, k_last, last_elem, acc_ovf;

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (int'(d) <= MAX_DIM);
  endfunction

  assign dim_bad   = !dim_ok(am_q) || !dim_ok(an_q) || !dim_ok(bm_q) ||
                     !dim_ok(bn_q) || (an_q != bm_q);
  assign k_last    = (k_q == an_q - 3'd1);
  assign last_elem = (i_q == am_q - 3'd1) && (j_q == bn_q - 3'd1);
  assign a_idx     = IW'(int'(i_q)*MAX_DIM + int'(k_q));
  assign b_idx     = IW'(int'(k_q)*MAX_DIM + int'(j_q));
  assign c_idx     = IW'(int'(i_q)*MAX_DIM + int'(j_q));
  assign prod      = ACC_WIDTH'(a_q[a_idx]) * ACC_WIDTH'(b_q[b_idx]);
  // any bit above the element range means the sum exceeded 2^ELEM_WIDTH-1
  assign acc_ovf   = |acc_q[ACC_WIDTH-1:ELEM_WIDTH];

  assign busy       = (state == CHECK) || (state == MAC) || (state == WRITE);
  assign done       = (state == DONE);
  assign matrix_out = c_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CHECK;
      CHECK:   state_nx = dim_bad ? DONE : MAC;
      MAC:     if (k_last) state_nx = WRITE;
      WRITE:   state_nx = last_elem ? DONE : MAC;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      am_q  <= '0;
      an_q  <= '0;
      bm_q  <= '0;
      bn_q  <= '0;
      sat_q <= 1'b0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      acc_q <= '0;
      err   <= 1'b0;
      ovf   <= 1'b0;
      valid <= 1'b0;
      c_m   <= '0;
      c_n   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q   <= matrixA_in;
          b_q   <= matrixB_in;
          am_q  <= a_m;
          an_q  <= a_n;
          bm_q  <= b_m;
          bn_q  <= b_n;
          sat_q <= sat_en;
          c_q   <= '0;
          c_m   <= '0;
          c_n   <= '0;
          valid <= 1'b0;
          err   <= 1'b0;
          ovf   <= 1'b0;
        end
        CHECK: begin
          i_q   <= '0;
          j_q   <= '0;
          k_q   <= '0;
          acc_q <= '0;
          if (dim_bad) err <= 1'b1;
        end
        MAC: begin
          acc_q <= acc_q + prod;
          k_q   <= k_q + 3'd1;
        end
        WRITE: begin
          c_q[c_idx] <= (acc_ovf && sat_q) ? {ELEM_WIDTH{1'b1}} : acc_q[ELEM_WIDTH-1:0];
          if (acc_ovf) ovf <= 1'b1;
          acc_q <= '0;
          k_q   <= '0;
          if (j_q == bn_q - 3'd1) begin
            j_q <= '0;
            i_q <= i_q + 3'd1;
          end else begin
            j_q <= j_q + 3'd1;
          end
          // publish result dims with the final write so they are good during done
          if (last_elem) begin
            c_m   <= am_q;
            c_n   <= bn_q;
            valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
